// File: rtl/stream_byte_packer.sv
// Packs a byte stream into DATA_BYTES-wide words with per-byte keep and frame-end flag.
// A single output register stage lets a new frame start while the previous word drains.
module stream_byte_packer #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic [DATA_BYTES-1:0]   m_keep,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [15:0]             frame_count
);

  localparam int IW = $clog2(DATA_BYTES);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [8*DATA_BYTES-1:0] asm_data_q, asm_data_d, asm_wr;
  logic [DATA_BYTES-1:0]   asm_keep_q, asm_keep_d, keep_wr;
  logic [8*DATA_BYTES-1:0] m_data_q, m_data_d;
  logic [DATA_BYTES-1:0]   m_keep_q, m_keep_d;
  logic                    m_last_q, m_last_d;
  logic [15:0]             fcnt_q, fcnt_d;
  logic                    in_xfer, out_xfer, final_byte;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (final_byte)    state_d = HOLD;
    else if (out_xfer) state_d = FILL;
  end

  always_comb begin
    m_valid = (state_q == HOLD);
    s_ready = !m_valid || m_ready;
  end

  assign in_xfer    = s_valid && s_ready;
  assign out_xfer   = m_valid && m_ready;
  assign final_byte = in_xfer && (s_last || idx_q == IW'(DATA_BYTES - 1));

  // The assembly word is cleared whenever a word is registered out, so a byte
  // arriving alongside an output transfer always lands in a fresh lane 0.
  always_comb begin
    asm_wr               = asm_data_q;
    asm_wr[8*idx_q +: 8] = s_data;
    keep_wr              = asm_keep_q;
    keep_wr[idx_q]       = 1'b1;
  end

  always_comb begin
    idx_d      = idx_q;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    fcnt_d     = fcnt_q + {15'd0, out_xfer && m_last_q};
    if (final_byte) begin
      m_data_d   = asm_wr;
      m_keep_d   = keep_wr;
      m_last_d   = s_last;
      asm_data_d = '0;
      asm_keep_d = '0;
      idx_d      = '0;
    end else if (in_xfer) begin
      asm_data_d = asm_wr;
      asm_keep_d = keep_wr;
      idx_d      = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      idx_q      <= idx_d;
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_keep      = m_keep_q;
  assign m_last      = m_last_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed bench for stream_byte_packer (DATA_BYTES=4) with hand-computed expectations.
module tb_stream_byte_packer;
  logic        clk, rst;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last, m_valid, m_ready;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;

  stream_byte_packer #(.DATA_BYTES(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with a byte presented: it must be discarded
    rst = 1'b1; m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
    step(); step();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_fcnt", frame_count, 0);
    rst = 1'b0; s_valid = 1'b0;
    step();
    chk("rst_discard", m_valid, 0);

    // Full 4-byte frame
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("f1_not_yet", m_valid, 0);
    send(8'h44, 1);
    chk("f1_valid", m_valid, 1);
    chk("f1_data", m_data, 64'h44332211);
    chk("f1_keep", m_keep, 4'hF);
    chk("f1_last", m_last, 1);
    idle();
    chk("f1_drained", m_valid, 0);
    chk("f1_fcnt", frame_count, 1);

    // Short frame
    send(8'hAA, 0); send(8'hBB, 1);
    chk("f2_data", m_data, 64'h0000BBAA);
    chk("f2_keep", m_keep, 4'h3);
    chk("f2_last", m_last, 1);
    idle();
    chk("f2_fcnt", frame_count, 2);

    // 8-byte continuous frame
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    chk("f3_w0_valid", m_valid, 1);
    chk("f3_w0_data", m_data, 64'h04030201);
    chk("f3_w0_last", m_last, 0);
    send(8'h05, 0);
    chk("f3_mid_valid", m_valid, 0);
    chk("f3_mid_fcnt", frame_count, 2);
    send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
    chk("f3_w1_valid", m_valid, 1);
    chk("f3_w1_data", m_data, 64'h08070605);
    chk("f3_w1_keep", m_keep, 4'hF);
    chk("f3_w1_last", m_last, 1);
    idle();
    chk("f3_fcnt", frame_count, 3);

    // Backpressure in HOLD for 5 cycles with next byte waiting
    m_ready = 1'b0;
    send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h34, 1);
    s_valid = 1'b1; s_data = 8'h41; s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, 64'h34333231);
      chk("bp_m_last", m_last, 1);
    end
    m_ready = 1'b1;
    #1;
    chk("bp_release_ready", s_ready, 1);
    step();
    chk("bp_fcnt", frame_count, 4);
    chk("bp_after_valid", m_valid, 0);
    send(8'h42, 0); send(8'h43, 0); send(8'h44, 1);
    chk("bp_next_data", m_data, 64'h44434241);
    chk("bp_next_keep", m_keep, 4'hF);
    idle();
    chk("bp_next_fcnt", frame_count, 5);

    // Reset mid-word, then idle-gap inside the next frame
    send(8'hA1, 0); send(8'hA2, 0);
    rst = 1'b1; s_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_fcnt", frame_count, 0);
    chk("mid_rst_valid", m_valid, 0);
    send(8'h55, 0); send(8'h66, 0);
    s_data = 8'hFF; s_last = 1'b1;
    idle();
    chk("gap_valid", m_valid, 0);
    send(8'h77, 0);
    chk("gap_valid2", m_valid, 0);
    send(8'h88, 1);
    chk("f5_data", m_data, 64'h88776655);
    chk("f5_keep", m_keep, 4'hF);
    chk("f5_last", m_last, 1);
    idle();
    chk("f5_fcnt", frame_count, 1);

    // 65536 back-to-back single-byte frames: counter wraps
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      send(8'(i), 1);
      chk("wrap_word", {m_valid, m_keep, m_data}, {1'b1, 4'h1, 24'h0, 8'(i)});
    end
    chk("wrap_pre", frame_count, 16'hFFFF);
    idle();
    chk("wrap_zero", frame_count, 16'h0000);
    chk("wrap_valid", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_byte_packer.md
STREAM_BYTE_PACKER -- requirements
Module: stream_byte_packer

Interface
REQ-001 SHALL have parameter: DATA_BYTES, default 4, number of input bytes packed per output word (legal 2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: s_data  input  8  input byte.
REQ-005 SHALL have port: s_valid  input  1  input byte valid.
REQ-006 SHALL have port: s_last  input  1  input byte is final byte of frame.
REQ-007 SHALL have port: s_ready  output  1  block accepts input byte this cycle.
REQ-008 SHALL have port: m_data  output  8*DATA_BYTES  packed word, byte 0 in bits [7:0].
REQ-009 SHALL have port: m_keep  output  DATA_BYTES  per-byte valid mask for m_data.
REQ-010 SHALL have port: m_last  output  1  word ends a frame.
REQ-011 SHALL have port: m_valid  output  1  output word valid.
REQ-012 SHALL have port: m_ready  input  1  downstream accepts output word.
REQ-013 SHALL have port: frame_count  output  16  frames emitted since reset.

Function
REQ-014 SHALL define input transfer as s_valid && s_ready, output transfer as m_valid && m_ready, both sampled at rising clk.
REQ-015 SHALL drive s_ready = !m_valid || m_ready (combinational; only combinational path input to output).
REQ-016 SHALL use two states: FILL (assembling, m_valid=0) and HOLD (word presented, m_valid=1).
REQ-017 SHALL keep byte index idx (0..DATA_BYTES-1); each input transfer writes s_data to byte lane idx of the assembly word, sets keep bit idx, increments idx.
REQ-018 SHALL, on input transfer with idx==DATA_BYTES-1 or s_last=1, register the word as m_data/m_keep, set m_last=s_last, enter HOLD and reset idx to 0, with m_valid asserted the following cycle (latency 1 cycle from final byte).
REQ-019 SHALL drive unfilled lanes of m_data to 0x00 and their m_keep bits to 0 (short frame: m_keep contiguous from bit 0).
REQ-020 SHALL hold m_data, m_keep, m_last, m_valid stable in HOLD while m_ready=0 (no input accepted).
REQ-021 SHALL, on output transfer with no simultaneous input transfer, return to FILL with m_valid=0 next cycle.
REQ-022 SHALL, on output transfer with simultaneous input transfer, write the new byte into lane 0 of a fresh word (previous contents cleared); if that byte has s_last=1 or DATA_BYTES reached, remain in HOLD presenting the new word next cycle (back-to-back words, no bubble).
REQ-023 SHALL increment frame_count by 1 on each output transfer with m_last=1, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL treat s_last on lane DATA_BYTES-1 as a full word with m_keep all ones and m_last=1.
REQ-025 SHALL ignore s_data/s_last when s_valid=0; s_valid deassertion mid-word SHALL not disturb idx or partial word.
REQ-026 SHALL sustain one byte per cycle at input when m_ready held 1.

Reset
REQ-027 SHALL, while rst=1 at a rising edge, set state FILL, idx=0, assembly word and keep 0, m_data=0, m_keep=0, m_last=0, m_valid=0, frame_count=0.
REQ-028 SHALL drive s_ready=1 during and after reset (m_valid=0), but SHALL discard any byte presented in a cycle where rst=1.
REQ-029 SHALL, on rst asserted mid-word or in HOLD, drop the partial or held word without emitting it.

Verification
REQ-030 SHALL cover: DATA_BYTES=4, bytes 0x11,0x22,0x33,0x44 (last on 0x44), m_ready=1 -> one word m_data=0x44332211, m_keep=0xF, m_last=1, frame_count=1.
REQ-031 SHALL cover: short frame 0xAA,0xBB (last on 0xBB) -> m_data=0x0000BBAA, m_keep=0x3, m_last=1.
REQ-032 SHALL cover: 8-byte frame 0x01..0x08 continuous, m_ready=1 -> words 0x04030201 (m_last=0) then 0x08070605 (m_last=1) on consecutive output cycles, no bubble.
REQ-033 SHALL cover: m_ready=0 for 5 cycles while in HOLD -> s_ready=0, outputs stable, no bytes lost after m_ready rises.
REQ-034 SHALL cover: rst pulsed after 2 of 4 bytes accepted -> no output word, next frame 0x55,0x66,0x77,0x88 emits 0x88776655, frame_count=1.
REQ-035 SHALL cover: 65536 single-byte frames -> frame_count wraps to 0x0000, each word m_keep=0x1.
